// File: rtl/onehot_index_encoder.sv
// Sequential one-hot/multi-hot to binary index encoder: emits every set bit's index, lowest first.
// Optional zero-bubble streaming between vectors when ONEHOT_INDEX_ENCODER_B2B_EN is defined.
`default_nettype none

module onehot_index_encoder #(
    parameter int  N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   pend;
    logic [N-1:0]   pend_nxt;
    logic           none_r;
    logic           none_nxt;
    logic           in_hs;
    logic           out_hs;

    function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    function automatic logic [N-1:0] clear_lowest(input logic [N-1:0] v);
        return v & (v - N'(1));
    endfunction

    function automatic logic at_most_one(input logic [N-1:0] v);
        return clear_lowest(v) == '0;
    endfunction

`ifdef ONEHOT_INDEX_ENCODER_B2B_EN
    // Last beat leaving frees the slot in the same cycle, so a new vector can load without a bubble.
    assign in_ready = (state == IDLE) || (out_valid && out_last && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        none_nxt  = none_r;
        if (out_hs) begin
            pend_nxt = clear_lowest(pend);
            if (out_last) state_nxt = IDLE;
        end
        // A new vector overrides the retiring one; only reachable on the last beat or from IDLE.
        if (in_hs) begin
            pend_nxt  = in_vec;
            none_nxt  = (in_vec == '0);
            state_nxt = EMIT;
        end
    end

    // Outputs are registered from next-state values so no in_* signal reaches out_* combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            none_r    <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            none_r    <= none_nxt;
            out_valid <= (state_nxt == EMIT);
            out_idx   <= (state_nxt == EMIT) ? lowest_idx(pend_nxt) : '0;
            out_last  <= (state_nxt == EMIT) && at_most_one(pend_nxt);
            out_none  <= (state_nxt == EMIT) && none_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_onehot_index_encoder.sv
// Scoreboard bench for onehot_index_encoder: expected beats queued at input handshake, checked on output handshake.
// Gap expectations follow ONEHOT_INDEX_ENCODER_B2B_EN.
`timescale 1ns/1ps

module tb_onehot_index_encoder;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
        logic       none;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         out_none;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    beat_t sb[$];
    int    beat_cyc[$];

    onehot_index_encoder #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_none (out_none)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [N-1:0] vec);
        int hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < N; i++) if (vec[i]) hi = i;
        if (hi < 0) begin
            b.idx = 2'd0; b.last = 1'b1; b.none = 1'b1;
            sb.push_back(b);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    b.idx = 2'(i); b.last = (i == hi); b.none = 1'b0;
                    sb.push_back(b);
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic offer(input logic [N-1:0] vec);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_vec   = vec;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                push_expected(vec);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("offer_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && out_valid === 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every accepted beat and checks stall stability.
    logic       stalled = 1'b0;
    logic [1:0] h_idx;
    logic       h_last;
    logic       h_none;
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1) begin
            if (stalled && out_valid) begin
                chk("stall_idx", 32'(out_idx), 32'(h_idx));
                chk("stall_last", 32'(out_last), 32'(h_last));
                chk("stall_none", 32'(out_none), 32'(h_none));
            end
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_idx", 32'(out_idx), 32'(e.idx));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                    chk("beat_none", 32'(out_none), 32'(e.none));
                end
            end
            stalled = out_valid && !out_ready;
            h_idx   = out_idx;
            h_last  = out_last;
            h_none  = out_none;
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_none", 32'(out_none), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Multi-bit vector, consumer always ready
        beat_cyc.delete();
        offer(4'b1011);
        in_valid = 1'b0;
        drain();
        chk("v1011_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3) begin
            chk("v1011_gap1", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
            chk("v1011_gap2", 32'(beat_cyc[2] - beat_cyc[1]), 32'd1);
        end
        chk("v1011_in_ready", 32'(in_ready), 32'd1);

        // All-zero vector
        beat_cyc.delete();
        offer(4'b0000);
        in_valid = 1'b0;
        drain();
        chk("v0000_beats", 32'(beat_cyc.size()), 32'd1);
        chk("v0000_idle", 32'(out_valid), 32'd0);

        // Stall with out_ready low for three cycles
        beat_cyc.delete();
        out_ready = 1'b0;
        offer(4'b1000);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_idx3", 32'(out_idx), 32'd3);
            chk("stall_last1", 32'(out_last), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        chk("v1000_beats", 32'(beat_cyc.size()), 32'd1);

        // Back-to-back vectors with in_valid held high
        beat_cyc.delete();
        offer(4'b0110);
        offer(4'b0001);
        in_valid = 1'b0;
        drain();
        chk("b2b_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3) begin
            chk("b2b_gap1", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
`ifdef ONEHOT_INDEX_ENCODER_B2B_EN
            chk("b2b_gap2", 32'(beat_cyc[2] - beat_cyc[1]), 32'd1);
`else
            chk("b2b_gap2", 32'(beat_cyc[2] - beat_cyc[1]), 32'd2);
`endif
        end

        // Reset during EMIT after the first beat has been accepted
        offer(4'b1111);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_out_none", 32'(out_none), 32'd0);
        sb.delete();
        beat_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_beats", 32'(beat_cyc.size()), 32'd0);
        offer(4'b0100);
        in_valid = 1'b0;
        drain();
        chk("v0100_beats", 32'(beat_cyc.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
